clk_div: RTL and testbench

CLK_DIV -- requirements
Module: clk_div

---
 rtl/clk_div_if.sv | 8 +
 rtl/clk_div.sv | 40 ++++
 tb/tb_clk_div.sv | 125 ++++++++++++
 3 files changed

// File: rtl/clk_div_if.sv
// Divided-clock output bundle: level clock plus one-cycle tick strobe.
interface clk_div_if;
    logic clkout;
    logic tick;

    modport master (output clkout, output tick);
    modport slave  (input  clkout, input  tick);
endinterface

// File: rtl/clk_div.sv
// Integer clock divider: registered clkout level and a tick strobe that
// marks each clkout rising edge, both in the clk domain.
module clk_div #(
    parameter int DIV_N       = 326,
    parameter int HIGH_CYCLES = (DIV_N + 1) / 2
) (
    input  logic      clk,
    input  logic      rst_n,
    clk_div_if.master bus
);

    if (DIV_N < 2 || HIGH_CYCLES < 1 || HIGH_CYCLES > DIV_N - 1) begin : g_bad
        $error("clk_div: illegal DIV_N / HIGH_CYCLES");
    end

    localparam int W = $clog2(DIV_N);
    localparam logic [W-1:0] LAST = W'(DIV_N - 1);
    localparam logic [W-1:0] HI   = W'(HIGH_CYCLES);

    logic [W-1:0] cnt;
    logic         clkout_q;
    logic         tick_q;

    // Outputs decode the pre-edge count, so they lag cnt by one cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt      <= '0;
            clkout_q <= 1'b0;
            tick_q   <= 1'b0;
        end else begin
            cnt      <= (cnt == LAST) ? '0 : cnt + 1'b1;
            clkout_q <= (cnt < HI);
            tick_q   <= (cnt == '0);
        end
    end

    assign bus.clkout = clkout_q;
    assign bus.tick   = tick_q;

endmodule

// File: tb/tb_clk_div.sv
// Randomized reset/run bench for three clk_div configurations with a
// per-edge phase model and a queue-based scoreboard.
module tb_clk_div;

    logic clk = 1'b0;
    logic rst_n = 1'b1;

    always #10 clk = ~clk;

    clk_div_if if0 ();
    clk_div_if if1 ();
    clk_div_if if2 ();

    clk_div #(.DIV_N(326), .HIGH_CYCLES(163)) u0 (
        .clk(clk), .rst_n(rst_n), .bus(if0));
    clk_div #(.DIV_N(5), .HIGH_CYCLES(3)) u1 (
        .clk(clk), .rst_n(rst_n), .bus(if1));
    clk_div #(.DIV_N(2), .HIGH_CYCLES(1)) u2 (
        .clk(clk), .rst_n(rst_n), .bus(if2));

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    int nn [3] = '{326, 5, 2};
    int hh [3] = '{163, 3, 1};
    int kk [3] = '{0, 0, 0};

    logic [1:0] q [3][$];

    function automatic logic [1:0] outs(input int d);
        case (d)
            0:       return {if0.clkout, if0.tick};
            1:       return {if1.clkout, if1.tick};
            default: return {if2.clkout, if2.tick};
        endcase
    endfunction

    // Edge k after release is phase (k-1) mod N of the waveform
    task automatic model(input logic r);
        int p;
        for (int d = 0; d < 3; d++) begin
            if (!r) begin
                kk[d] = 0;
                q[d].push_back(2'b00);
            end else begin
                kk[d] = kk[d] + 1;
                p = (kk[d] - 1) % nn[d];
                q[d].push_back({p < hh[d], p == 0});
            end
        end
    endtask

    task automatic check_zero(input string tag);
        for (int d = 0; d < 3; d++) begin
            checks++;
            if (outs(d) !== 2'b00) begin
                errors++;
                $display("FAIL %s dut%0d got %b exp 00", tag, d, outs(d));
            end
        end
    endtask

    task automatic step(input logic r);
        @(negedge clk);
        #2;
        if (rst_n && !r) begin
            rst_n = 1'b0;
            #1;
            check_zero("async_rst");
        end else begin
            rst_n = r;
        end
        model(r);
    endtask

    task automatic run(input int n, input logic r);
        for (int i = 0; i < n; i++) step(r);
    endtask

    always @(negedge clk) begin
        logic [1:0] e;
        cyc++;
        for (int d = 0; d < 3; d++) begin
            if (q[d].size() != 0) begin
                e = q[d].pop_front();
                checks++;
                if (outs(d) !== e) begin
                    errors++;
                    $display("FAIL edge dut%0d cyc%0d got %b exp %b",
                             d, cyc, outs(d), e);
                end
            end
        end
    end

    initial begin
        #1 rst_n = 1'b0;
        #4 check_zero("pre_edge_rst");
        model(1'b0);
        run(4, 1'b0);
        run(3300, 1'b1);
        run(200, 1'b1);
        run(3, 1'b0);
        run(400, 1'b1);
        for (int s = 0; s < 6; s++) begin
            run(int'($urandom_range(1, 700)), 1'b1);
            run(int'($urandom_range(1, 3)), 1'b0);
        end
        run(int'($urandom_range(20, 400)), 1'b1);
        @(negedge clk);
        @(negedge clk);
        for (int d = 0; d < 3; d++) begin
            checks++;
            if (q[d].size() != 0) begin
                errors++;
                $display("FAIL drain dut%0d got %0d left exp 0",
                         d, q[d].size());
            end
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
